slurm16_cpu_instruction_prefetch: RTL and testbench

//  Instruction prefetch queue between the instruction memory port and the slurm16_cpu_pipeline fetch interface.
//  It streams sequential instruction words into a small FIFO ahead of demand, then serves pipeline requests from the FIFO.
//  A request for any address other than the stream head address (branch, interrupt, (i)ret) flushes the queue.

---
 rtl/slurm16_cpu_instruction_prefetch.sv | 145 ++++++++++++++
 tb/tb_slurm16_cpu_instruction_prefetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm16_cpu_instruction_prefetch.sv
// Instruction prefetch queue: streams sequential words from instruction memory into a small FIFO
// and serves in-order pipeline requests from it; any out-of-sequence request flushes and restarts.
module slurm16_cpu_instruction_prefetch #(
  parameter int                   DEPTH      = 4,
  parameter int                   ADDR_BITS  = 15,
  parameter int                   DATA_BITS  = 16,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 instruction_request,
  input  logic [ADDR_BITS-1:0] instruction_address,
  output logic                 instruction_valid,
  output logic [DATA_BITS-1:0] instruction_in,
  output logic [ADDR_BITS-1:0] instruction_address_in,
  output logic                 mem_rd_req,
  output logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic                 mem_rd_ready,
  input  logic                 mem_rd_valid,
  input  logic [DATA_BITS-1:0] mem_rd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [DATA_BITS-1:0] fifo_q [DEPTH];
  logic [DATA_BITS-1:0] fifo_d [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d, outstanding_q, outstanding_d, discard_cnt_q, discard_cnt_d;
  logic [ADDR_BITS-1:0] head_addr_q, head_addr_d, fetch_pc_q, fetch_pc_d;
  logic                 run_q, run_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [ADDR_BITS-1:0] addr_out_q, addr_out_d;

  logic          flush_now, hit, accept, drop, push, credit_ok;
  logic [SW-1:0] used;

  // Request/credit decode; run_q keeps the memory request quiet until the first cycle after reset.
  always_comb begin
    used      = {1'b0, count_q} + {1'b0, outstanding_q};
    credit_ok = (used < SW'(DEPTH));
    flush_now = instruction_request && (instruction_address != head_addr_q);
    hit       = instruction_request && !flush_now && (count_q != '0);
    mem_rd_req = run_q && credit_ok && !flush_now;
    accept    = mem_rd_req && mem_rd_ready;
    drop      = mem_rd_valid && (discard_cnt_q != '0);
    push      = mem_rd_valid && !drop && !flush_now;
  end

  // Next-state computation for queue, stream pointers and registered pipeline outputs.
  always_comb begin
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    discard_cnt_d = discard_cnt_q;
    head_addr_d   = head_addr_q;
    fetch_pc_d    = fetch_pc_q;
    run_d         = 1'b1;
    valid_d       = 1'b0;
    data_d        = data_q;
    addr_out_d    = addr_out_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(mem_rd_valid);

    if (push) begin
      fifo_d[wr_ptr_q] = mem_rd_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (hit) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      head_addr_d = head_addr_q + ADDR_BITS'(1);
      valid_d     = 1'b1;
      data_d      = fifo_q[rd_ptr_q];
      addr_out_d  = head_addr_q;
    end else begin
      valid_d = 1'b0;
    end

    if (flush_now) begin
      // Everything still in flight, including a word landing this cycle, belongs to the old stream.
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      head_addr_d   = instruction_address;
      fetch_pc_d    = instruction_address;
      discard_cnt_d = outstanding_q - CW'(mem_rd_valid);
    end else begin
      count_d = count_q + CW'(push) - CW'(hit);
      if (accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_BITS'(1);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (drop) begin
        discard_cnt_d = discard_cnt_q - CW'(1);
      end else begin
        discard_cnt_d = discard_cnt_q;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      head_addr_q   <= RESET_ADDR;
      fetch_pc_q    <= RESET_ADDR;
      run_q         <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      addr_out_q    <= '0;
    end else begin
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      head_addr_q   <= head_addr_d;
      fetch_pc_q    <= fetch_pc_d;
      run_q         <= run_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      addr_out_q    <= addr_out_d;
    end
  end

  assign instruction_valid      = valid_q;
  assign instruction_in         = data_q;
  assign instruction_address_in = addr_out_q;
  assign mem_rd_addr            = fetch_pc_q;

endmodule

// File: tb/tb_slurm16_cpu_instruction_prefetch.sv
// Bench for the instruction prefetch queue: in-order memory model with random latency plus a
// stream-level pipeline model that checks every delivered word against its address.
module tb_slurm16_cpu_instruction_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, req, rdy, mvalid;
  logic [14:0] addr;
  logic [15:0] mdata;
  logic        valid, mrreq;
  logic [15:0] din;
  logic [14:0] ain, mraddr;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [14:0] head;
  logic [15:0] prev_in;
  logic [14:0] prev_ain;
  int          wait_cnt;
  logic        got_valid;
  logic [14:0] got_addr;

  int          lat_min = 1;
  int          lat_max = 1;
  int          n_acc   = 0;
  int          tcyc    = 0;
  logic [14:0] acc_log[$];
  logic [14:0] pend_a[$];
  int          pend_t[$];

  always #5 clk = ~clk;

  slurm16_cpu_instruction_prefetch #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RSTb(rst_n),
    .instruction_request(req), .instruction_address(addr),
    .instruction_valid(valid), .instruction_in(din), .instruction_address_in(ain),
    .mem_rd_req(mrreq), .mem_rd_addr(mraddr), .mem_rd_ready(rdy),
    .mem_rd_valid(mvalid), .mem_rd_data(mdata)
  );

  function automatic logic [15:0] word(input logic [14:0] a);
    return {1'b1, a ^ 15'h2B3C};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction memory: accepts at the edge, returns in order 1..N cycles later.
  initial begin
    logic        acc;
    logic [14:0] acc_addr;
    mvalid = 1'b0;
    mdata  = 16'h0000;
    forever begin
      @(negedge clk);
      acc      = mrreq && rdy && rst_n;
      acc_addr = mraddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend_a.delete();
        pend_t.delete();
        acc = 1'b0;
      end
      if (acc) begin
        pend_a.push_back(acc_addr);
        pend_t.push_back(tcyc + $urandom_range(lat_max, lat_min));
        acc_log.push_back(acc_addr);
        n_acc++;
      end
      tcyc++;
      if (rst_n && pend_a.size() > 0 && pend_t[0] <= tcyc) begin
        mvalid = 1'b1;
        mdata  = word(pend_a.pop_front());
        void'(pend_t.pop_front());
      end else begin
        mvalid = 1'b0;
      end
    end
  end

  // One pipeline cycle: drive request, then judge the registered response after the edge.
  task automatic cyc(input logic r, input logic [14:0] a);
    logic miss;
    miss = r && (a != head);
    req  = r;
    addr = a;
    #1;
    if (miss) check("flush_no_issue", 32'(mrreq), 32'd0);
    @(posedge clk);
    #2;
    got_valid = valid;
    got_addr  = ain;
    if (!r || miss) begin
      check("no_valid", 32'(valid), 32'd0);
      if (miss) head = a;
      wait_cnt = 0;
    end else if (valid) begin
      check("addr", 32'(ain), 32'(a));
      check("data", 32'(din), 32'(word(a)));
      head     = a + 15'd1;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      check("liveness", 32'(wait_cnt < 40), 32'd1);
    end
    if (!valid) begin
      check("hold_data", 32'(din), 32'(prev_in));
      check("hold_addr", 32'(ain), 32'(prev_ain));
    end
    prev_in  = din;
    prev_ain = ain;
  endtask

  task automatic model_reset();
    head     = 15'h0000;
    prev_in  = 16'h0000;
    prev_ain = 15'h0000;
    wait_cnt = 0;
  endtask

  task automatic stream_until_valid(input string tag);
    int k;
    k = 0;
    got_valid = 1'b0;
    while (!got_valid && k < 40) begin
      cyc(1'b1, head);
      k++;
    end
    check(tag, 32'(got_valid), 32'd1);
  endtask

  initial begin
    int          k, n0;
    logic [14:0] a0, a;
    logic        r;
    logic [14:0] seen[$];

    rst_n = 1'b0; req = 1'b0; addr = 15'h0000; rdy = 1'b1;
    model_reset();

    // reset state
    @(posedge clk);
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_in", 32'(din), 32'd0);
    check("rst_ain", 32'(ain), 32'd0);
    check("rst_req", 32'(mrreq), 32'd0);
    check("rst_maddr", 32'(mraddr), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: first word latency, then back-to-back delivery
    lat_min = 1; lat_max = 1;
    k = 0;
    got_valid = 1'b0;
    while (!got_valid && k < 10) begin
      cyc(1'b1, head);
      k++;
    end
    check("first_valid_by_4", 32'(got_valid && k <= 4), 32'd1);
    check("first_addr", 32'(got_addr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, head);
      check("b2b_valid", 32'(got_valid), 32'd1);
    end

    // 2: stall fills exactly DEPTH credits, then a burst with memory blocked
    lat_min = 1; lat_max = 2;
    cyc(1'b1, 15'h0200);
    n0 = n_acc;
    repeat (10) cyc(1'b0, head);
    check("stall_accepts", 32'(n_acc - n0), 32'(DEPTH));
    check("stall_req_low", 32'(mrreq), 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, head);
      check("burst_hit", 32'(got_valid), 32'd1);
    end
    rdy = 1'b1;

    // 3: miss with words in flight
    lat_min = 3; lat_max = 3;
    k = 0;
    while (pend_a.size() < 2 && k < 20) begin
      cyc(1'b1, head);
      k++;
    end
    check("inflight_2", 32'(pend_a.size() >= 2), 32'd1);
    acc_log.delete();
    cyc(1'b1, 15'h0040);
    stream_until_valid("miss_deliver");
    check("miss_first_addr", 32'(got_addr), 32'h40);
    check("miss_refetch", 32'(acc_log.size() > 0 ? acc_log[0] : 15'h7FFF), 32'h40);

    // 4: miss in the same cycle as a returning word
    lat_min = 1; lat_max = 3;
    k = 0;
    while (!mvalid && k < 50) begin
      cyc(1'b1, head);
      k++;
    end
    check("ret_seen", 32'(mvalid), 32'd1);
    cyc(1'b1, 15'h0100);
    stream_until_valid("miss_ret_deliver");
    check("miss_ret_addr", 32'(got_addr), 32'h100);

    // 5: address wrap
    cyc(1'b1, 15'h7FFE);
    k = 0;
    while (seen.size() < 3 && k < 60) begin
      cyc(1'b1, head);
      if (got_valid) seen.push_back(got_addr);
      k++;
    end
    check("wrap_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("wrap_a0", 32'(seen[0]), 32'h7FFE);
      check("wrap_a1", 32'(seen[1]), 32'h7FFF);
      check("wrap_a2", 32'(seen[2]), 32'h0000);
    end

    // 6: memory not ready, then asynchronous reset mid-stream
    rdy = 1'b0;
    a0 = mraddr;
    n0 = n_acc;
    repeat (5) cyc(1'b1, head);
    check("nrdy_accepts", 32'(n_acc - n0), 32'd0);
    check("nrdy_addr", 32'(mraddr), 32'(a0));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_in", 32'(din), 32'd0);
    check("arst_ain", 32'(ain), 32'd0);
    check("arst_req", 32'(mrreq), 32'd0);
    check("arst_maddr", 32'(mraddr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    rdy = 1'b1;
    lat_min = 1; lat_max = 1;
    stream_until_valid("restart_deliver");
    check("restart_addr", 32'(got_addr), 32'd0);

    // random traffic against the stream model
    lat_min = 1; lat_max = 4;
    repeat (1500) begin
      rdy = ($urandom_range(3, 0) != 0);
      r   = ($urandom_range(7, 0) != 0);
      a   = head;
      if ($urandom_range(15, 0) == 0) begin
        if ($urandom_range(3, 0) == 0) a = 15'h7FFC + 15'($urandom_range(3, 0));
        else a = 15'($urandom);
      end
      cyc(r, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
